// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder and the Dadda multiplier top.
// The stage record typedef lives in pipelined_adder, where its field widths are known.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_rca_chunk.sv
// Purely combinational WIDTH-bit ripple-carry adder built from full-adder cells.
// With PIPELINED_ADDER_OVF_EN defined it also exports the carry into its MSB.
module rca_chunk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             msb_ci
`endif
);

    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[WIDTH];
`ifdef PIPELINED_ADDER_OVF_EN
    assign msb_ci = c[WIDTH-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined carry-propagate adder: one WIDTH/STAGES-bit chunk resolved per stage, carry registered between.
// Optional signed-overflow output ovf enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    localparam int C = chunk_width(WIDTH, STAGES);

    typedef struct packed {
        logic             valid;
        logic             carry;
`ifdef PIPELINED_ADDER_OVF_EN
        logic             msb_ci;
`endif
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t         stage_q [STAGES];
    stage_t         stage_d [STAGES];
    logic [C-1:0]   op_a    [STAGES];
    logic [C-1:0]   op_b    [STAGES];
    logic [C-1:0]   chunk_s [STAGES];
    logic           chunk_ci[STAGES];
    logic           chunk_co[STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
    logic           chunk_msb_ci[STAGES];
`endif
    logic           adv;

    // A stalled result at the output freezes every stage, so no bubble is ever squeezed out.
    assign adv      = !stage_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.WIDTH(C)) u_rca (
            .a     (op_a[k]),
            .b     (op_b[k]),
            .ci    (chunk_ci[k]),
            .s     (chunk_s[k]),
            .co    (chunk_co[k])
`ifdef PIPELINED_ADDER_OVF_EN
            ,
            .msb_ci(chunk_msb_ci[k])
`endif
        );
    end

    always_comb begin
        // NOTE: every element gets a full default before any field is patched, so no latch is inferred.
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                op_a[k]           = a[C-1:0];
                op_b[k]           = b[C-1:0];
                chunk_ci[k]       = ci;
                stage_d[k]        = '0;
                stage_d[k].valid  = in_valid;
                stage_d[k].a      = a;
                stage_d[k].b      = b;
            end else begin
                op_a[k]           = stage_q[k-1].a[k*C +: C];
                op_b[k]           = stage_q[k-1].b[k*C +: C];
                chunk_ci[k]       = stage_q[k-1].carry;
                stage_d[k]        = stage_q[k-1];
            end
            stage_d[k].carry          = chunk_co[k];
            stage_d[k].sum[k*C +: C]  = chunk_s[k];
`ifdef PIPELINED_ADDER_OVF_EN
            // Only the last stage's value survives, and that is the carry into bit WIDTH-1.
            stage_d[k].msb_ci         = chunk_msb_ci[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (!rst_n) begin
                // NOTE: data registers are cleared too, so sum/co read 0 after reset rather than stale values.
                stage_q[k] <= '0;
            end else if (adv) begin
                // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].sum;
    assign co        = stage_q[STAGES-1].carry;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf       = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].msb_ci;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): vector table, scoreboard, corner sequences.
// Also exercises ovf when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        exp_t             e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .co       (co)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH:0] full;
        exp_t r;
        full  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        r.sum = full[WIDTH-1:0];
        r.co  = full[WIDTH];
        r.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard consumer: compare on every drain, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("co", 32'(co), 32'(e.co));
`ifdef PIPELINED_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Present one operand pair and return #1 after the edge that accepted it.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input exp_t e);
        bit done = 0;
        a        = x;
        b        = y;
        ci       = c;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    vec_t hv[4];

    initial begin
        vecs[0] = '{a:16'h1234, b:16'h4321, ci:1'b0, e:'{sum:16'h5555, co:1'b0, ovf:1'b0}};
        vecs[1] = '{a:16'hFFFF, b:16'h0001, ci:1'b0, e:'{sum:16'h0000, co:1'b1, ovf:1'b0}};
        vecs[2] = '{a:16'hFFFF, b:16'hFFFF, ci:1'b1, e:'{sum:16'hFFFF, co:1'b1, ovf:1'b0}};
        vecs[3] = '{a:16'h7FFF, b:16'h0001, ci:1'b0, e:'{sum:16'h8000, co:1'b0, ovf:1'b1}};
        vecs[4] = '{a:16'h8000, b:16'h8000, ci:1'b0, e:'{sum:16'h0000, co:1'b1, ovf:1'b1}};
        vecs[5] = '{a:16'h0001, b:16'hFFFF, ci:1'b0, e:'{sum:16'h0000, co:1'b1, ovf:1'b0}};
        vecs[6] = '{a:16'h00FF, b:16'h0001, ci:1'b0, e:'{sum:16'h0100, co:1'b0, ovf:1'b0}};
        vecs[7] = '{a:16'h0000, b:16'h0000, ci:1'b1, e:'{sum:16'h0001, co:1'b0, ovf:1'b0}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // First-result latency: visible only after the third edge following the accept.
        send(vecs[0].a, vecs[0].b, vecs[0].ci, vecs[0].e);
        in_valid = 1'b0;
        check("lat_t0", 32'(out_valid), 32'd0);
        tick();
        check("lat_t1", 32'(out_valid), 32'd0);
        tick();
        check("lat_t2", 32'(out_valid), 32'd0);
        tick();
        check("lat_t3", 32'(out_valid), 32'd1);
        wait_drain();

        for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].e);
        in_valid = 1'b0;
        wait_drain();

        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] x, y;
            logic             c;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            c = 1'($urandom);
            send(x, y, c, model(x, y, c));
        end
        in_valid = 1'b0;
        wait_drain();

        // Back-to-back: in_ready stays high and results come out on four consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            hv[i].a  = WIDTH'(16'h1111 * (i + 1));
            hv[i].b  = WIDTH'(16'h0F0F << i);
            hv[i].ci = 1'(i);
            hv[i].e  = model(hv[i].a, hv[i].b, hv[i].ci);
        end
        for (int i = 0; i < 4; i++) begin
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            send(hv[i].a, hv[i].b, hv[i].ci, hv[i].e);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("b2b_empty", 32'(out_valid), 32'd0);
        wait_drain();

        // Backpressure: fill the pipe with out_ready low, hold three cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(hv[i].b, hv[i].a, 1'b0, model(hv[i].b, hv[i].a, 1'b0));
        in_valid = 1'b1;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(model(hv[0].b, hv[0].a, 1'b0).sum));
            check("hold_co", 32'(co), 32'(model(hv[0].b, hv[0].a, 1'b0).co));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("hold_after_drain", 32'(out_valid), 32'd0);

        // Reset with three results in flight: nothing stale may ever reach the output.
        for (int i = 0; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].e);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        send(vecs[4].a, vecs[4].b, vecs[4].ci, vecs[4].e);
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
